uart_tx_ctrl: RTL and testbench

// - UART TX frame controller/serializer; consumes P_data plus Par_bit from the parity stage, drives the serial line.
// - Accepts one parallel word per Data_valid pulse while idle; emits start, WIDTH data bits LSB first, optional parity, stop.
// - Sits directly downstream of parity; both blocks share clk and Data_valid, so Par_bit is registered on the accept edge.

---
 rtl/uart_tx_ctrl_if.sv | 22 ++
 rtl/uart_tx_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Parallel-side handshake and serial line of the UART TX frame controller.
// master = upstream word source plus parity stage, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] P_data;
  logic             Data_valid;
  logic             PAR_EN;
  logic             Par_bit;
  logic             TX_OUT;
  logic             Busy;

  modport master (
    output P_data, Data_valid, PAR_EN, Par_bit,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_data, Data_valid, PAR_EN, Par_bit,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame serializer: start, WIDTH data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to emit two stop bits instead of one.
module uart_tx_ctrl #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input logic          clk,
  input logic          rst,
  uart_tx_ctrl_if.slave bus
);

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_CLKS = 2 * CLKS_PER_BIT;
`else
  localparam int STOP_CLKS = CLKS_PER_BIT;
`endif

  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BAUD_W = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   latch_r;
  logic               par_en_r;
  logic [BIT_W-1:0]   bit_r;
  logic [BAUD_W-1:0]  baud_r;
  logic               tx_r;
  logic               busy_r;

  logic [BIT_W-1:0]   bit_nxt_s;
  logic [BAUD_W-1:0]  baud_nxt_s;
  logic               baud_end_s;

  assign bus.TX_OUT = tx_r;
  assign bus.Busy   = busy_r;

  // Counter increments and end-of-bit detect; the stop phase may span two bit times.
  always_comb begin
    bit_nxt_s  = bit_r + BIT_W'(1);
    baud_nxt_s = baud_r + BAUD_W'(1);
    if (state_r == STOP) begin
      baud_end_s = (baud_r == STOP_LAST);
    end else begin
      baud_end_s = (baud_r == BAUD_LAST);
    end
  end

  // Frame FSM; the line value for the next bit is registered on the bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      latch_r  <= '0;
      par_en_r <= 1'b0;
      bit_r    <= '0;
      baud_r   <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          bit_r  <= '0;
          baud_r <= '0;
          if (bus.Data_valid) begin
            latch_r  <= bus.P_data;
            par_en_r <= bus.PAR_EN;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= START;
          end
        end
        START: begin
          if (baud_end_s) begin
            baud_r  <= '0;
            bit_r   <= '0;
            tx_r    <= latch_r[0];
            state_r <= DATA;
          end else begin
            baud_r <= baud_nxt_s;
          end
        end
        DATA: begin
          if (baud_end_s) begin
            baud_r <= '0;
            if (bit_r == BIT_LAST) begin
              bit_r <= '0;
              // Par_bit was registered upstream on the accept edge, so it is stable here.
              if (par_en_r) begin
                tx_r    <= bus.Par_bit;
                state_r <= PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= STOP;
              end
            end else begin
              bit_r <= bit_nxt_s;
              tx_r  <= latch_r[bit_nxt_s];
            end
          end else begin
            baud_r <= baud_nxt_s;
          end
        end
        PARITY: begin
          if (baud_end_s) begin
            baud_r  <= '0;
            tx_r    <= 1'b1;
            state_r <= STOP;
          end else begin
            baud_r <= baud_nxt_s;
          end
        end
        STOP: begin
          tx_r <= 1'b1;
          if (baud_end_s) begin
            baud_r  <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            baud_r <= baud_nxt_s;
          end
        end
        default: begin
          state_r <= IDLE;
          bit_r   <= '0;
          baud_r  <= '0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a baud-1 and a baud-4 instance, each with
// a registered parity stage sharing Data_valid, checked against a bit-list frame model.
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.WIDTH(8)) bus1 ();
  uart_tx_ctrl_if #(.WIDTH(8)) bus4 ();

  logic par_type1, par_type4;
  logic par1_r, par4_r;

  // Parity stage: registers parity of whatever word is presented with Data_valid.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      par1_r <= 1'b0;
      par4_r <= 1'b0;
    end else begin
      if (bus1.Data_valid) par1_r <= (^bus1.P_data) ^ par_type1;
      if (bus4.Data_valid) par4_r <= (^bus4.P_data) ^ par_type4;
    end
  end
  assign bus1.Par_bit = par1_r;
  assign bus4.Par_bit = par4_r;

  uart_tx_ctrl #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  uart_tx_ctrl #(.WIDTH(8), .CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int checks = 0;
  int errors = 0;

  typedef bit frame_t[$];

  // Line value per clock after the accept edge, while Busy is high.
  function automatic frame_t build_frame(input logic [7:0] d, input bit pen, input bit ptype, input int cpb);
    frame_t bits;
    frame_t q;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(bit'((^d) ^ ptype));
    for (int s = 0; s < STOPS; s++) bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < cpb; c++) q.push_back(bits[i]);
    return q;
  endfunction

  task automatic accept1(input logic [7:0] d, input bit pen, input bit pt);
    @(negedge clk);
    bus1.P_data = d;
    bus1.PAR_EN = pen;
    par_type1 = pt;
    bus1.Data_valid = 1'b1;
    @(negedge clk);
    bus1.Data_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (bus1.TX_OUT !== 1'b1 || bus1.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_b1: tx=%b busy=%b expected tx=1 busy=0", bus1.TX_OUT, bus1.Busy);
    end
    checks++;
    if (bus4.TX_OUT !== 1'b1 || bus4.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_b4: tx=%b busy=%b expected tx=1 busy=0", bus4.TX_OUT, bus4.Busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frames;
    logic [7:0] dv [3] = '{8'hA5, 8'hAB, 8'h00};
    bit         pv [3] = '{1'b1, 1'b1, 1'b0};
    bit         tv [3] = '{1'b0, 1'b1, 1'b0};
    int         bl [3] = '{11, 11, 10};
    for (int k = 0; k < 9; k++) begin
      logic [7:0] d;
      bit pen, pt;
      frame_t exp;
      int busy_n;
      if (k < 3) begin
        d = dv[k]; pen = pv[k]; pt = tv[k];
      end else begin
        d = 8'($urandom); pen = 1'($urandom_range(0, 1)); pt = 1'($urandom_range(0, 1));
      end
      exp = build_frame(d, pen, pt, 1);
      accept1(d, pen, pt);
      busy_n = 0;
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (bus1.TX_OUT !== exp[i] || bus1.Busy !== 1'b1) begin
          errors++;
          $display("FAIL frame%0d_bit%0d: tx=%b busy=%b expected tx=%b busy=1", k, i, bus1.TX_OUT, bus1.Busy, exp[i]);
        end
        busy_n += int'(bus1.Busy);
        @(negedge clk);
      end
      checks++;
      if (bus1.TX_OUT !== 1'b1 || bus1.Busy !== 1'b0) begin
        errors++;
        $display("FAIL frame%0d_idle: tx=%b busy=%b expected tx=1 busy=0", k, bus1.TX_OUT, bus1.Busy);
      end
      if (k < 3) begin
        checks++;
        if (busy_n !== bl[k] + STOPS - 1) begin
          errors++;
          $display("FAIL frame%0d_busy_len: got %0d expected %0d", k, busy_n, bl[k] + STOPS - 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    frame_t exp;
    logic [7:0] d;
    exp = build_frame(8'hA5, 1'b1, 1'b0, 1);
    accept1(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (bus1.TX_OUT !== exp[4]) begin
      errors++;
      $display("FAIL mid_rst_pre: tx=%b expected %b", bus1.TX_OUT, exp[4]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus1.TX_OUT !== 1'b1 || bus1.Busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_abort: tx=%b busy=%b expected tx=1 busy=0", bus1.TX_OUT, bus1.Busy);
    end
    @(negedge clk);
    rst = 1'b0;
    d = 8'($urandom);
    exp = build_frame(d, 1'b1, 1'b1, 1);
    accept1(d, 1'b1, 1'b1);
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (bus1.TX_OUT !== exp[i] || bus1.Busy !== 1'b1) begin
        errors++;
        $display("FAIL post_rst_bit%0d: tx=%b busy=%b expected tx=%b busy=1", i, bus1.TX_OUT, bus1.Busy, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus1.TX_OUT !== 1'b1 || bus1.Busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle: tx=%b busy=%b expected tx=1 busy=0", bus1.TX_OUT, bus1.Busy);
    end
  endtask

  task automatic test_back_to_back;
    frame_t exp1, exp2;
    exp1 = build_frame(8'hA5, 1'b0, 1'b0, 1);
    exp2 = build_frame(8'hFF, 1'b1, 1'b1, 1);
    @(negedge clk);
    bus1.P_data = 8'hA5;
    bus1.PAR_EN = 1'b0;
    par_type1 = 1'b0;
    bus1.Data_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < exp1.size(); i++) begin
      checks++;
      if (bus1.TX_OUT !== exp1[i] || bus1.Busy !== 1'b1) begin
        errors++;
        $display("FAIL held_bit%0d: tx=%b busy=%b expected tx=%b busy=1", i, bus1.TX_OUT, bus1.Busy, exp1[i]);
      end
      if (i == 3) begin
        bus1.P_data = 8'hFF;
        bus1.PAR_EN = 1'b1;
        par_type1 = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (bus1.TX_OUT !== 1'b1 || bus1.Busy !== 1'b0) begin
      errors++;
      $display("FAIL held_gap: tx=%b busy=%b expected tx=1 busy=0", bus1.TX_OUT, bus1.Busy);
    end
    @(negedge clk);
    bus1.Data_valid = 1'b0;
    for (int i = 0; i < exp2.size(); i++) begin
      checks++;
      if (bus1.TX_OUT !== exp2[i] || bus1.Busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bit%0d: tx=%b busy=%b expected tx=%b busy=1", i, bus1.TX_OUT, bus1.Busy, exp2[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus1.TX_OUT !== 1'b1 || bus1.Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: tx=%b busy=%b expected tx=1 busy=0", bus1.TX_OUT, bus1.Busy);
    end
  endtask

  task automatic test_slow_baud;
    frame_t exp;
    int busy_n;
    exp = build_frame(8'hA5, 1'b1, 1'b0, 4);
    @(negedge clk);
    bus4.P_data = 8'hA5;
    bus4.PAR_EN = 1'b1;
    par_type4 = 1'b0;
    bus4.Data_valid = 1'b1;
    @(negedge clk);
    bus4.Data_valid = 1'b0;
    bus4.P_data = 8'h3C;
    busy_n = 0;
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (bus4.TX_OUT !== exp[i] || bus4.Busy !== 1'b1) begin
        errors++;
        $display("FAIL baud4_cyc%0d: tx=%b busy=%b expected tx=%b busy=1", i, bus4.TX_OUT, bus4.Busy, exp[i]);
      end
      busy_n += int'(bus4.Busy);
      @(negedge clk);
    end
    checks++;
    if (bus4.TX_OUT !== 1'b1 || bus4.Busy !== 1'b0) begin
      errors++;
      $display("FAIL baud4_idle: tx=%b busy=%b expected tx=1 busy=0", bus4.TX_OUT, bus4.Busy);
    end
    checks++;
    if (busy_n !== 40 + 4 * STOPS) begin
      errors++;
      $display("FAIL baud4_busy_len: got %0d expected %0d", busy_n, 40 + 4 * STOPS);
    end
  endtask

  initial begin
    bus1.P_data = 8'h00; bus1.PAR_EN = 1'b0; bus1.Data_valid = 1'b0;
    bus4.P_data = 8'h00; bus4.PAR_EN = 1'b0; bus4.Data_valid = 1'b0;
    par_type1 = 1'b0;
    par_type4 = 1'b0;
    test_reset();
    test_frames();
    test_reset_mid_frame();
    test_back_to_back();
    test_slow_baud();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
